arith_arb: RTL

ARITH_ARB -- requirements
Module: arith_arb

---
 rtl/arith_arb_if.sv | 55 +++++
 rtl/arith_arb.sv | 108 ++++++++++
 2 files changed

// File: rtl/arith_arb_if.sv
// Bundle between two requesters, the arbiter and the shared arith unit.
// The arbiter connects through the slave modport; the surrounding environment
// (requesters and arith unit) connects through the master modport.
interface arith_arb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             req0_valid_i;
    logic             req1_valid_i;
    logic             req0_ready_o;
    logic             req1_ready_o;
    logic [2:0]       req0_funct_i;
    logic [2:0]       req1_funct_i;
    logic [WIDTH-1:0] req0_op1_i;
    logic [WIDTH-1:0] req1_op1_i;
    logic [WIDTH-1:0] req0_op2_i;
    logic [WIDTH-1:0] req1_op2_i;
    logic             rsp0_valid_o;
    logic             rsp1_valid_o;
    logic             rsp0_ready_i;
    logic             rsp1_ready_i;
    logic [WIDTH-1:0] rsp0_res_o;
    logic [WIDTH-1:0] rsp1_res_o;
    logic [2:0]       arith_funct_o;
    logic [WIDTH-1:0] arith_op1_o;
    logic [WIDTH-1:0] arith_op2_o;
    logic [WIDTH-1:0] arith_res_i;
    logic [CNT_W-1:0] ops_cnt_o;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        input  req0_funct_i, req1_funct_i,
        input  req0_op1_i, req1_op1_i, req0_op2_i, req1_op2_i,
        input  rsp0_ready_i, rsp1_ready_i,
        input  arith_res_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o,
        output rsp0_res_o, rsp1_res_o,
        output arith_funct_o, arith_op1_o, arith_op2_o,
        output ops_cnt_o
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        output req0_funct_i, req1_funct_i,
        output req0_op1_i, req1_op1_i, req0_op2_i, req1_op2_i,
        output rsp0_ready_i, rsp1_ready_i,
        output arith_res_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o,
        input  rsp0_res_o, rsp1_res_o,
        input  arith_funct_o, arith_op1_o, arith_op2_o,
        input  ops_cnt_o
    );
endinterface

// File: rtl/arith_arb.sv
// Round-robin arbiter sharing one combinational arith unit between two
// requesters. Each requester owns a one-deep result slot; a request is only
// accepted when its slot is free or being drained in the same cycle.
module arith_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic        clk_i,
    input logic        rst_n_i,
    arith_arb_if.slave bus
);

    logic             elig0, elig1;
    logic             gnt0, gnt1;
    logic             ptr_q, ptr_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_res_q, rsp0_res_d;
    logic [WIDTH-1:0] rsp1_res_q, rsp1_res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Eligibility and grant; grants are gated by reset so ready stays low while held.
    always_comb begin
        elig0 = bus.req0_valid_i & (~rsp0_valid_q | bus.rsp0_ready_i);
        elig1 = bus.req1_valid_i & (~rsp1_valid_q | bus.rsp1_ready_i);
        gnt0  = rst_n_i & elig0 & (~elig1 | ~ptr_q);
        gnt1  = rst_n_i & elig1 & (~elig0 | ptr_q);
    end

    // Operand mux to the shared unit; requester 0 is the idle default.
    always_comb begin
        if (gnt1) begin
            bus.arith_funct_o = bus.req1_funct_i;
            bus.arith_op1_o   = bus.req1_op1_i;
            bus.arith_op2_o   = bus.req1_op2_i;
        end else begin
            bus.arith_funct_o = bus.req0_funct_i;
            bus.arith_op1_o   = bus.req0_op1_i;
            bus.arith_op2_o   = bus.req0_op2_i;
        end
    end

    // Next state: pointer, result slots and operation counter.
    always_comb begin
        ptr_d        = ptr_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp1_res_d   = rsp1_res_q;
        cnt_d        = cnt_q;

        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end

        // A grant in the same cycle as a drain refills the slot, so valid stays high.
        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = bus.arith_res_i;
        end else if (bus.rsp0_ready_i) begin
            rsp0_valid_d = 1'b0;
        end

        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = bus.arith_res_i;
        end else if (bus.rsp1_ready_i) begin
            rsp1_valid_d = 1'b0;
        end

        if (gnt0 | gnt1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_res_q   <= '0;
            cnt_q        <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_res_q   <= rsp1_res_d;
            cnt_q        <= cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.req0_ready_o = gnt0;
        bus.req1_ready_o = gnt1;
        bus.rsp0_valid_o = rsp0_valid_q;
        bus.rsp1_valid_o = rsp1_valid_q;
        bus.rsp0_res_o   = rsp0_res_q;
        bus.rsp1_res_o   = rsp1_res_q;
        bus.ops_cnt_o    = cnt_q;
    end

endmodule
